// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES encrypt core among NREQ requesters.
// Optional per-requester CBC chaining is enabled by defining AES_ARB_CBC_CHAIN_EN.
module aes_core_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 32
) (
  input  logic                vclk,
  input  logic                vrst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*128-1:0] req_key,
  input  logic [NREQ*128-1:0] req_text,
  input  logic [NREQ-1:0]     req_first,
  input  logic [NREQ*128-1:0] req_iv,
  output logic [NREQ-1:0]     gnt,
  output logic                core_ld,
  output logic [127:0]        core_key,
  output logic [127:0]        core_text_in,
  input  logic                core_done,
  input  logic [127:0]        core_text_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [127:0]        rsp_text,
  output logic                rsp_err,
  output logic                busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_e;

  state_e                 state_q;
  logic [IDW-1:0]         ptr_q, id_q, win;
  logic [CW-1:0]          cnt_q;
  logic [NREQ-1:0]        gnt_q;
  logic                   ld_q, valid_q, err_q, busy_q, any_req;
  logic [127:0]           key_q, text_q, rtext_q, text_d;
  logic [NREQ-1:0][127:0] key_a, text_a;

  assign key_a  = req_key;
  assign text_a = req_text;

  // Upper pass finds the lowest request above the pointer; the wrap pass
  // only runs when nothing above it is pending.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (IDW'(i) > ptr_q)) begin
        win     = IDW'(i);
        any_req = 1'b1;
      end
    end
    if (!any_req) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (req[i]) begin
          win     = IDW'(i);
          any_req = 1'b1;
        end
      end
    end
  end

`ifdef AES_ARB_CBC_CHAIN_EN
  logic [NREQ-1:0][127:0] iv_a, chain_q;

  assign iv_a   = req_iv;
  assign text_d = text_a[win] ^ (req_first[win] ? iv_a[win] : chain_q[win]);

  // A timed-out block leaves the chain untouched.
  always_ff @(posedge vclk or negedge vrst) begin
    if (!vrst) begin
      chain_q <= '0;
    end else if (state_q == WAIT && core_done) begin
      chain_q[id_q] <= core_text_out;
    end
  end
`else
  logic unused_chain_in;

  assign text_d          = text_a[win];
  assign unused_chain_in = ^{req_first, req_iv};
`endif

  always_ff @(posedge vclk or negedge vrst) begin
    if (!vrst) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      ld_q    <= 1'b0;
      key_q   <= '0;
      text_q  <= '0;
      id_q    <= '0;
      rtext_q <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          key_q   <= key_a[win];
          text_q  <= text_d;
          id_q    <= win;
          ptr_q   <= win;
          gnt_q   <= NREQ'(1) << win;
          ld_q    <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= LOAD;
        end
        LOAD: begin
          gnt_q   <= '0;
          ld_q    <= 1'b0;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (core_done) begin
            rtext_q <= core_text_out;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rtext_q <= '0;
            err_q   <= 1'b1;
            valid_q <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt          = gnt_q;
  assign core_ld      = ld_q;
  assign core_key     = key_q;
  assign core_text_in = text_q;
  assign rsp_valid    = valid_q;
  assign rsp_id       = id_q;
  assign rsp_text     = rtext_q;
  assign rsp_err      = err_q;
  assign busy         = busy_q;

endmodule
